// File: rtl/keycode_debounce.sv
// Keycode debouncer: a raw keycode must hold for STABLE_CYCLES edges before it commits.
// Committed presses are queued in a small first-word-fallthrough event FIFO.
module keycode_debounce #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode_raw,
  output logic [7:0] key_stable,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  input  logic       evt_ready,
  output logic       overflow
);

  localparam int unsigned CntW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned PtrW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);
  localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StHeld} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cand_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      key_q;
  logic            press_q, press_d;
  logic            rel_q, rel_d;
  logic            ovf_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;

  logic same, commit, change;
  logic push, pop, full, push_ok;

  always_comb begin
    same    = (keycode_raw == cand_q);
    commit  = same && (cnt_q == CntMax);
    change  = commit && (cand_q != key_q);
    state_d = state_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (change && (cand_q != 8'h00)) begin
          state_d = StHeld;
          press_d = 1'b1;
        end
      end
      StHeld: begin
        if (change) begin
          rel_d = 1'b1;
          if (cand_q == 8'h00) state_d = StIdle;
          else                 press_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A full queue still accepts a push when the head leaves on the same edge.
  always_comb begin
    pop     = (count_q != '0) && evt_ready;
    push    = press_d;
    full    = (count_q == CountFull);
    push_ok = push && (!full || pop);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cand_q   <= 8'h00;
      cnt_q    <= '0;
      key_q    <= 8'h00;
      state_q  <= StIdle;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (!same) begin
        cand_q <= keycode_raw;
        cnt_q  <= '0;
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (change) key_q <= cand_q;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      if (push && !push_ok) ovf_q <= 1'b1;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_ok && !pop)      count_q <= count_q + (PtrW + 1)'(1);
      else if (!push_ok && pop) count_q <= count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && push_ok) mem_q[wr_ptr_q] <= cand_q;
  end

  assign key_stable    = key_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign evt_valid     = (count_q != '0);
  assign evt_code      = mem_q[rd_ptr_q];
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_keycode_debounce.sv
// Randomized and directed bench for keycode_debounce against a run-length / queue model.
module tb_keycode_debounce;

  localparam int unsigned S = 4;
  localparam int unsigned D = 4;

  logic       Clk;
  logic       Reset;
  logic [7:0] keycode_raw;
  logic [7:0] key_stable;
  logic       press_pulse;
  logic       release_pulse;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ready;
  logic       overflow;

  keycode_debounce #(
    .STABLE_CYCLES(S),
    .FIFO_DEPTH   (D)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .keycode_raw  (keycode_raw),
    .key_stable   (key_stable),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .evt_valid    (evt_valid),
    .evt_code     (evt_code),
    .evt_ready    (evt_ready),
    .overflow     (overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Model: a value commits once it has been sampled on more than S consecutive edges.
  int         run;
  logic [7:0] m_last;
  logic [7:0] m_key;
  bit         m_press, m_rel, m_ovf;
  logic [7:0] m_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [7:0] raw, input logic rdy, input logic rst);
    bit pop;
    if (rst) begin
      run = 1; m_last = 8'h00; m_key = 8'h00;
      m_press = 0; m_rel = 0; m_ovf = 0;
      m_q.delete();
      return;
    end
    if (raw == m_last) begin
      if (run < 1000) run++;
    end else begin
      run = 1;
    end
    m_last  = raw;
    m_press = 0;
    m_rel   = 0;
    pop = (m_q.size() > 0) && rdy;
    if (run >= S + 1 && raw != m_key) begin
      m_press = (raw != 8'h00);
      m_rel   = (m_key != 8'h00);
      m_key   = raw;
    end
    if (pop) void'(m_q.pop_front());
    if (m_press) begin
      if (m_q.size() < D) m_q.push_back(raw);
      else                m_ovf = 1;
    end
  endtask

  task automatic step(input logic [7:0] raw, input logic rdy, input logic rst);
    keycode_raw = raw;
    evt_ready   = rdy;
    Reset       = rst;
    @(posedge Clk);
    model_edge(raw, rdy, rst);
    #1;
    check_eq("key_stable", 32'(key_stable), 32'(m_key));
    check_eq("press_pulse", 32'(press_pulse), 32'(m_press));
    check_eq("release_pulse", 32'(release_pulse), 32'(m_rel));
    check_eq("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    if (m_q.size() > 0) check_eq("evt_code", 32'(evt_code), 32'(m_q[0]));
  endtask

  task automatic hold(input logic [7:0] raw, input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(raw, rdy, 1'b0);
  endtask

  initial begin
    logic [7:0] vals [6];
    vals = '{8'h00, 8'h00, 8'h04, 8'h28, 8'h2C, 8'h05};
    keycode_raw = 8'h00;
    evt_ready   = 1'b0;
    Reset       = 1'b1;

    // Reset state and basic press: commit on the 5th edge of 8'h28.
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    hold(8'h28, 4, 1'b0);
    check_eq("no_early_commit", 32'(key_stable), 32'h00);
    step(8'h28, 1'b0, 1'b0);
    check_eq("press_key", 32'(key_stable), 32'h28);
    check_eq("press_once", 32'(press_pulse), 32'h1);
    hold(8'h28, 5, 1'b0);
    check_eq("head_28", 32'(evt_code), 32'h28);

    // Key change 28 -> 2C: both pulses, queue drains 28 then 2C.
    step(8'h2C, 1'b0, 1'b0);
    hold(8'h2C, 3, 1'b0);
    step(8'h2C, 1'b0, 1'b0);
    check_eq("swap_rel", 32'(release_pulse), 32'h1);
    check_eq("swap_press", 32'(press_pulse), 32'h1);
    check_eq("swap_head", 32'(evt_code), 32'h28);
    step(8'h2C, 1'b1, 1'b0);
    check_eq("swap_second", 32'(evt_code), 32'h2C);
    step(8'h2C, 1'b1, 1'b0);
    check_eq("swap_drained", 32'(evt_valid), 32'h0);

    // Bounce shorter than the stable window never commits.
    step(8'h00, 1'b0, 1'b1);
    hold(8'h28, 3, 1'b0);
    hold(8'h00, 6, 1'b0);
    check_eq("bounce_key", 32'(key_stable), 32'h00);
    check_eq("bounce_valid", 32'(evt_valid), 32'h0);

    // Five presses with no consumer: fifth dropped, overflow sticky.
    step(8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      hold(8'h04 + 8'(k), 6, 1'b0);
      hold(8'h00, 6, 1'b0);
    end
    check_eq("ovf_set", 32'(overflow), 32'h1);
    check_eq("ovf_head", 32'(evt_code), 32'h04);

    // Same again but the consumer pops on the fifth push edge.
    step(8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      hold(8'h04 + 8'(k), 6, 1'b0);
      hold(8'h00, 6, 1'b0);
    end
    hold(8'h08, 4, 1'b0);
    step(8'h08, 1'b1, 1'b0);
    check_eq("full_pop_push_ovf", 32'(overflow), 32'h0);
    for (int k = 0; k < 4; k++) begin
      check_eq("full_pop_order", 32'(evt_code), 32'(8'h05 + 8'(k)));
      step(8'h08, 1'b1, 1'b0);
    end
    check_eq("full_drained", 32'(evt_valid), 32'h0);

    // Reset mid-count with events queued.
    step(8'h00, 1'b0, 1'b1);
    hold(8'h28, 6, 1'b0);
    hold(8'h2C, 6, 1'b0);
    hold(8'h04, 3, 1'b0);
    step(8'h04, 1'b0, 1'b1);
    check_eq("rst_valid", 32'(evt_valid), 32'h0);
    check_eq("rst_key", 32'(key_stable), 32'h00);
    hold(8'h28, 5, 1'b0);
    check_eq("rst_recommit", 32'(key_stable), 32'h28);

    // Randomized segments.
    for (int seg = 0; seg < 300; seg++) begin
      logic [7:0] v;
      int len;
      v   = vals[$urandom_range(0, 5)];
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++)
        step(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keycode_debounce.md
KEYCODE_DEBOUNCE -- requirements
Module: keycode_debounce

Interface
REQ-001 Parameter: STABLE_CYCLES, 16, consecutive clock edges a raw keycode must hold before commit (legal range 2..255).
REQ-002 Parameter: FIFO_DEPTH, 4, press-event queue entries (power of two, 2..16).
REQ-003 Clk  input  1  system clock; all state updates on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 keycode_raw  input  8  unfiltered keycode from USB keyboard path; 8'h00 = no key.
REQ-006 key_stable  output  8  debounced keycode; feeds downstream input-control FSM.
REQ-007 press_pulse  output  1  one-cycle pulse, new nonzero key committed.
REQ-008 release_pulse  output  1  one-cycle pulse, previously committed nonzero key left.
REQ-009 evt_valid  output  1  press-event queue non-empty.
REQ-010 evt_code  output  8  keycode at queue head; valid only while evt_valid=1.
REQ-011 evt_ready  input  1  consumer accepts head when evt_valid=1.
REQ-012 overflow  output  1  sticky flag, press event dropped on full queue.

Function
REQ-013 Internal candidate register cand[7:0] and counter cnt (width ceil(log2(STABLE_CYCLES))) shall track raw input.
REQ-014 Each edge: keycode_raw != cand -> cand<=keycode_raw, cnt<=0.
REQ-015 Each edge: keycode_raw == cand and cnt < STABLE_CYCLES-1 -> cnt increments.
REQ-016 Each edge: keycode_raw == cand and cnt == STABLE_CYCLES-1 -> commit: cnt holds, key_stable<=cand if cand != key_stable; no action if equal.
REQ-017 Latency: value first loaded into cand at edge E and held shall appear on key_stable after edge E+STABLE_CYCLES; any change before that restarts count, no commit.
REQ-018 FSM states IDLE (key_stable==0) and HELD (key_stable!=0); reset state IDLE.
REQ-019 IDLE, commit nonzero -> HELD, press_pulse=1 for the cycle after commit edge.
REQ-020 HELD, commit 8'h00 -> IDLE, release_pulse=1 for the cycle after commit edge.
REQ-021 HELD, commit different nonzero code -> stay HELD, release_pulse and press_pulse both 1 same cycle.
REQ-022 Pulses shall be registered, aligned with the cycle key_stable first shows the new value, and never exceed one cycle per commit.
REQ-023 Every press_pulse shall push the newly committed code into the queue on the commit edge.
REQ-024 Queue is first-word-fallthrough: evt_valid = not empty, evt_code = head; pushed entry visible on the cycle after push edge.
REQ-025 Pop occurs on an edge with evt_valid=1 and evt_ready=1; evt_ready with empty queue shall be ignored, no pointer movement.
REQ-026 Push on full queue without same-edge pop: entry dropped, queue unchanged, overflow<=1.
REQ-027 Push on full queue with same-edge pop: both performed, count stays FIFO_DEPTH, no overflow.
REQ-028 Push and pop same edge on non-empty queue: count unchanged, order preserved.
REQ-029 Pointers shall wrap modulo FIFO_DEPTH; occupancy count width log2(FIFO_DEPTH)+1.
REQ-030 overflow shall remain 1 until Reset.

Reset
REQ-031 Reset=1 at an edge: key_stable=8'h00, cand=8'h00, cnt=0, state IDLE, press_pulse=0, release_pulse=0, queue empty (evt_valid=0), overflow=0, from the following cycle.
REQ-032 Reset mid-count or mid-queue shall discard in-progress count and all queued events; no pulse generated by reset.
REQ-033 Reset has priority over every other update on the same edge.

Verification (STABLE_CYCLES=4, FIFO_DEPTH=4)
REQ-034 Reset, then keycode_raw=8'h28 held 10 cycles -> key_stable=8'h28 after 4th edge past first sample, press_pulse exactly one cycle, evt_valid=1, evt_code=8'h28.
REQ-035 keycode_raw=8'h28 for 3 cycles then 8'h00 -> key_stable stays 8'h00, no pulses, evt_valid=0.
REQ-036 Stable 8'h28 then 8'h2C held -> release_pulse and press_pulse same cycle, key_stable=8'h2C, queue yields 8'h28 then 8'h2C with evt_ready=1.
REQ-037 evt_ready=0, five distinct presses (8'h04..8'h08, each separated by 8'h00) -> queue holds 8'h04..8'h07, overflow=1; repeat with evt_ready=1 on 5th push edge -> 8'h08 accepted, overflow=0.
REQ-038 Reset asserted at cnt=2 with two queued events -> next cycle all outputs 0, evt_valid=0; subsequent stable 8'h28 commits normally.
